// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the HI/LO multiply/divide controller.
package muldiv_pkg;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   localparam logic [1:0] MD_NONE     = 2'b00;
   localparam logic [1:0] MD_SIGNED   = 2'b01;
   localparam logic [1:0] MD_UNSIGNED = 2'b10;

   localparam logic [1:0] HILO_HI = 2'b01;
   localparam logic [1:0] HILO_LO = 2'b10;

   function automatic logic md_valid(input logic [1:0] con);
      return (con == MD_SIGNED) || (con == MD_UNSIGNED);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider datapath: one quotient bit per step, signs applied on the fix view.
module div_iter (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        step,
   input  logic        fix,
   input  logic        sign_en,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   logic [31:0] r, q, d;
   logic        neg_q, neg_r;
   logic        neg_a, neg_b;
   logic [32:0] shifted, diff;

   always_comb begin
      neg_a   = sign_en & op_a[31];
      neg_b   = sign_en & op_b[31];
      shifted = {r, q[31]};
      // bit 32 of the difference is the borrow of the trial subtract
      diff    = shifted - {1'b0, d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r     <= '0;
         q     <= '0;
         d     <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (start) begin
         r     <= '0;
         q     <= neg_a ? -op_a : op_a;
         d     <= neg_b ? -op_b : op_b;
         neg_q <= neg_a ^ neg_b;
         neg_r <= neg_a;
      end else if (step) begin
         if (!diff[32]) begin
            r <= diff[31:0];
            q <= {q[30:0], 1'b1};
         end else begin
            r <= shifted[31:0];
            q <= {q[30:0], 1'b0};
         end
      end
   end

   assign quot = (fix && neg_q) ? -q : q;
   assign rem  = (fix && neg_r) ? -r : r;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: start acceptance, latency counting, commit, MF/MT access and stall.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mul_con,
   input  logic [1:0]  div_con,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [1:0]  hilo_rd,
   input  logic [1:0]  hilo_wr,
   input  logic [31:0] hilo_wdata,
   input  logic        flush,
   output logic [31:0] hilo_rdata,
   output logic        stall_o,
   output logic        busy,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(DIV_ITER);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi, lo;
   logic [63:0]      prod, prod_next, a_ext, b_ext;
   logic             mul_valid, div_valid, start_mul, start_div, cnt_zero;
   logic             is_busy;
   logic [31:0]      quot, rem;

   assign mul_valid = md_valid(mul_con);
   assign div_valid = md_valid(div_con);
   assign start_mul = (state == IDLE) && mul_valid && !flush;
   assign start_div = (state == IDLE) && div_valid && !mul_valid && !flush;
   assign cnt_zero  = (cnt == '0);
   assign is_busy   = (state != IDLE);

   // Product is taken at acceptance so MUL_LAT=1 can still commit on the next edge
   always_comb begin
      a_ext     = {{32{(mul_con == MD_SIGNED) & op_a[31]}}, op_a};
      b_ext     = {{32{(mul_con == MD_SIGNED) & op_b[31]}}, op_b};
      prod_next = a_ext * b_ext;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_mul)      state_next = MUL;
            else if (start_div) state_next = DIV;
         end
         MUL:     if (flush || cnt_zero) state_next = IDLE;
         DIV: begin
            if (flush)         state_next = IDLE;
            else if (cnt_zero) state_next = FIX;
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = is_busy;
      stall_o    = is_busy && (mul_valid || div_valid ||
                               (hilo_rd != MD_NONE) || (hilo_wr != MD_NONE));
      hilo_rdata = '0;
      if (!is_busy) begin
         if (hilo_rd == HILO_HI)      hilo_rdata = hi;
         else if (hilo_rd == HILO_LO) hilo_rdata = lo;
      end
   end

   // Flush suppresses every data update, including a commit due on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         hi   <= '0;
         lo   <= '0;
         prod <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: begin
               if (hilo_wr == HILO_HI)      hi <= hilo_wdata;
               else if (hilo_wr == HILO_LO) lo <= hilo_wdata;
               if (start_mul) begin
                  prod <= prod_next;
                  cnt  <= CNT_W'(MUL_LAT - 1);
               end else if (start_div) begin
                  cnt  <= CNT_W'(DIV_ITER - 1);
               end
            end
            MUL: begin
               if (cnt_zero) begin
                  hi <= prod[63:32];
                  lo <= prod[31:0];
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DIV: if (!cnt_zero) cnt <= cnt - CNT_W'(1);
            FIX: begin
               hi <= rem;
               lo <= quot;
            end
            default: ;
         endcase
      end
   end

   div_iter u_div (
      .clk     (clk),
      .reset   (reset),
      .start   (start_div),
      .step    (state == DIV),
      .fix     (state == FIX),
      .sign_en (div_con == MD_SIGNED),
      .op_a    (op_a),
      .op_b    (op_b),
      .quot    (quot),
      .rem     (rem)
   );

   assign hi_o = hi;
   assign lo_o = lo;

   a_single_start: assert property (@(posedge clk) disable iff (reset)
                                    !(mul_valid && div_valid));

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO queued at issue, compared at commit.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MUL_LAT  = 2;
   localparam int DIV_ITER = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mul_con = '0, div_con = '0, hilo_rd = '0, hilo_wr = '0;
   logic [31:0] op_a = '0, op_b = '0, hilo_wdata = '0;
   logic        flush = 1'b0;
   logic [31:0] hilo_rdata, hi_o, lo_o;
   logic        stall_o, busy;

   typedef struct packed {logic [31:0] hi; logic [31:0] lo;} res_t;
   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
      .clk(clk), .reset(reset), .mul_con(mul_con), .div_con(div_con),
      .op_a(op_a), .op_b(op_b), .hilo_rd(hilo_rd), .hilo_wr(hilo_wr),
      .hilo_wdata(hilo_wdata), .flush(flush), .hilo_rdata(hilo_rdata),
      .stall_o(stall_o), .busy(busy), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   function automatic res_t model_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint          p;
      longint unsigned u;
      if (sgn) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return res_t'(p);
      end
      u = a;
      u = u * b;
      return res_t'(u);
   endfunction

   function automatic res_t model_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      res_t r;
      int   sa, sv;
      if (b == 32'd0) begin
         r.hi = a;
         r.lo = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      end else if (sgn) begin
         sa   = a;
         sv   = b;
         r.lo = sa / sv;
         r.hi = sa % sv;
      end else begin
         r.lo = a / b;
         r.hi = a % b;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] mc, input logic [1:0] dc,
                        input logic [31:0] a, input logic [31:0] b);
      mul_con = mc; div_con = dc; op_a = a; op_b = b;
      tick();
      mul_con = MD_NONE; div_con = MD_NONE;
   endtask

   task automatic wait_idle(input int limit, output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < limit) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; hilo_rd = HILO_HI;
      tick();
      n_checks++;
      if ({busy, stall_o, hi_o, lo_o, hilo_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b stall=%b hi=%h lo=%h rdata=%h want all 0",
                  busy, stall_o, hi_o, lo_o, hilo_rdata);
      end
      hilo_rd = MD_NONE; reset = 1'b0;
      tick();
   endtask

   task automatic test_mult();
      logic [31:0] ta [3];
      logic [31:0] tv [3];
      bit          ts [3];
      res_t        e;
      int          cyc;
      ta = '{32'hFFFF_FFFD, 32'h1234_5678, 32'h8000_0000};
      tv = '{32'h0000_0005, 32'h9ABC_DEF0, 32'h8000_0000};
      ts = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         sb.push_back(model_mul(ta[i], tv[i], ts[i]));
         issue(ts[i] ? MD_SIGNED : MD_UNSIGNED, MD_NONE, ta[i], tv[i]);
         n_checks++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
         wait_idle(10, cyc);
         n_checks++;
         if (cyc != MUL_LAT) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d want %0d", i, cyc, MUL_LAT); end
         e = sb.pop_front();
         n_checks++;
         if (hi_o !== e.hi) begin n_fail++; $display("FAIL mult_hi[%0d]: got %h want %h", i, hi_o, e.hi); end
         n_checks++;
         if (lo_o !== e.lo) begin n_fail++; $display("FAIL mult_lo[%0d]: got %h want %h", i, lo_o, e.lo); end
      end
   endtask

   task automatic test_div();
      logic [31:0] ta [4];
      logic [31:0] tv [4];
      bit          ts [4];
      res_t        e;
      int          cyc;
      ta = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
      tv = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      ts = '{1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         sb.push_back(model_div(ta[i], tv[i], ts[i]));
         issue(MD_NONE, ts[i] ? MD_SIGNED : MD_UNSIGNED, ta[i], tv[i]);
         wait_idle(60, cyc);
         n_checks++;
         if (cyc != DIV_ITER + 1) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, cyc, DIV_ITER + 1); end
         e = sb.pop_front();
         n_checks++;
         if (lo_o !== e.lo) begin n_fail++; $display("FAIL div_quot[%0d]: got %h want %h", i, lo_o, e.lo); end
         n_checks++;
         if (hi_o !== e.hi) begin n_fail++; $display("FAIL div_rem[%0d]: got %h want %h", i, hi_o, e.hi); end
      end
   endtask

   task automatic test_mflo_stall();
      res_t e;
      int   n;
      sb.push_back(model_div(32'd1000, 32'd9, 1'b0));
      issue(MD_NONE, MD_UNSIGNED, 32'd1000, 32'd9);
      tick();
      hilo_rd = HILO_LO;
      #1;
      n = 0;
      while (stall_o === 1'b1 && n < 64) begin
         n++;
         tick();
         #1;
      end
      n_checks++;
      if (n != DIV_ITER) begin n_fail++; $display("FAIL mflo_stall_cycles: got %0d want %0d", n, DIV_ITER); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mflo_idle: got busy=%b want 0", busy); end
      e = sb.pop_front();
      n_checks++;
      if (hilo_rdata !== e.lo) begin n_fail++; $display("FAIL mflo_rdata: got %h want %h", hilo_rdata, e.lo); end
      hilo_rd = MD_NONE;
      tick();
   endtask

   task automatic test_mthi_mfhi();
      hilo_wr = HILO_HI; hilo_wdata = 32'h1234_5678;
      tick();
      hilo_wr = MD_NONE; hilo_rd = HILO_HI;
      #1;
      n_checks++;
      if (hilo_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL mfhi_rdata: got %h want 12345678", hilo_rdata); end
      hilo_rd = MD_NONE; hilo_wr = HILO_LO; hilo_wdata = 32'h9ABC_DEF0;
      tick();
      hilo_wr = MD_NONE; hilo_rd = HILO_LO;
      #1;
      n_checks++;
      if (hilo_rdata !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL mflo_rdata_mt: got %h want 9abcdef0", hilo_rdata); end
      n_checks++;
      if (hi_o !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_keeps_hi: got %h want 12345678", hi_o); end
      hilo_rd = 2'b11;
      #1;
      n_checks++;
      if (hilo_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_none_zero: got %h want 0", hilo_rdata); end
      hilo_rd = MD_NONE;
      tick();
   endtask

   task automatic test_back_to_back();
      res_t e;
      int   n, cyc;
      sb.push_back(model_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
      issue(MD_UNSIGNED, MD_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      mul_con = MD_UNSIGNED; op_a = 32'd7; op_b = 32'd9;
      sb.push_back(model_mul(32'd7, 32'd9, 1'b0));
      #1;
      n = 0;
      while (stall_o === 1'b1 && n < 20) begin
         n++;
         tick();
         #1;
      end
      n_checks++;
      if (n != MUL_LAT) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want %0d", n, MUL_LAT); end
      e = sb.pop_front();
      n_checks++;
      if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
         n_fail++; $display("FAIL b2b_first: got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo);
      end
      tick();
      mul_con = MD_NONE;
      wait_idle(10, cyc);
      n_checks++;
      if (cyc != MUL_LAT) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc, MUL_LAT); end
      e = sb.pop_front();
      n_checks++;
      if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
         n_fail++; $display("FAIL b2b_second: got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo);
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] ta [2];
      bit          ts [2];
      res_t        e;
      int          cyc;
      ta = '{32'h0000_ABCD, 32'hFFFF_FF00};
      ts = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         sb.push_back(model_div(ta[i], 32'd0, ts[i]));
         issue(MD_NONE, ts[i] ? MD_SIGNED : MD_UNSIGNED, ta[i], 32'd0);
         wait_idle(60, cyc);
         n_checks++;
         if (cyc != DIV_ITER + 1) begin n_fail++; $display("FAIL divz_latency[%0d]: got %0d want %0d", i, cyc, DIV_ITER + 1); end
         e = sb.pop_front();
         n_checks++;
         if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            n_fail++; $display("FAIL divz_result[%0d]: got %h_%h want %h_%h", i, hi_o, lo_o, e.hi, e.lo);
         end
      end
   endtask

   task automatic test_flush();
      hilo_wr = HILO_HI; hilo_wdata = 32'hAAAA_5555;
      tick();
      hilo_wr = HILO_LO; hilo_wdata = 32'h0F0F_0F0F;
      tick();
      hilo_wr = MD_NONE;
      // flush during the 10th divide iteration
      issue(MD_NONE, MD_SIGNED, 32'd100, 32'd3);
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_div_idle: got busy=%b want 0", busy); end
      repeat (DIV_ITER + 3) tick();
      n_checks++;
      if ({hi_o, lo_o} !== {32'hAAAA_5555, 32'h0F0F_0F0F}) begin
         n_fail++; $display("FAIL flush_div_hilo: got %h_%h want aaaa5555_0f0f0f0f", hi_o, lo_o);
      end
      // flush landing on the multiply commit edge
      issue(MD_SIGNED, MD_NONE, 32'd3, 32'd4);
      repeat (MUL_LAT - 1) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if ({busy, hi_o, lo_o} !== {1'b0, 32'hAAAA_5555, 32'h0F0F_0F0F}) begin
         n_fail++; $display("FAIL flush_mul_commit: got busy=%b %h_%h want 0 aaaa5555_0f0f0f0f", busy, hi_o, lo_o);
      end
      // flush landing on the sign-fix commit edge
      issue(MD_NONE, MD_UNSIGNED, 32'd50, 32'd5);
      repeat (DIV_ITER) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if ({busy, hi_o, lo_o} !== {1'b0, 32'hAAAA_5555, 32'h0F0F_0F0F}) begin
         n_fail++; $display("FAIL flush_fix_commit: got busy=%b %h_%h want 0 aaaa5555_0f0f0f0f", busy, hi_o, lo_o);
      end
      // start and MTHI presented together with flush are ignored
      mul_con = MD_SIGNED; op_a = 32'd2; op_b = 32'd2;
      hilo_wr = HILO_HI; hilo_wdata = 32'hDEAD_BEEF; flush = 1'b1;
      tick();
      mul_con = MD_NONE; hilo_wr = MD_NONE; flush = 1'b0;
      n_checks++;
      if ({busy, hi_o} !== {1'b0, 32'hAAAA_5555}) begin
         n_fail++; $display("FAIL flush_ignores_start_mt: got busy=%b hi=%h want 0 aaaa5555", busy, hi_o);
      end
   endtask

   task automatic test_reset_mid_mul();
      hilo_wr = HILO_HI; hilo_wdata = 32'h1357_2468;
      tick();
      hilo_wr = MD_NONE;
      issue(MD_SIGNED, MD_NONE, 32'd5, 32'd6);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mul_started: got busy=%b want 1", busy); end
      reset = 1'b1;
      #1;
      hilo_rd = HILO_HI;
      #1;
      n_checks++;
      if ({busy, stall_o, hi_o, lo_o, hilo_rdata} !== '0) begin
         n_fail++; $display("FAIL rst_mid_mul_outputs: got busy=%b stall=%b hi=%h lo=%h rdata=%h want all 0",
                            busy, stall_o, hi_o, lo_o, hilo_rdata);
      end
      hilo_rd = MD_NONE;
      tick();
      reset = 1'b0;
      repeat (MUL_LAT + 2) tick();
      n_checks++;
      if ({busy, hi_o, lo_o} !== '0) begin
         n_fail++; $display("FAIL rst_not_resumed: got busy=%b %h_%h want 0 0_0", busy, hi_o, lo_o);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mflo_stall();
      test_mthi_mfhi();
      test_back_to_back();
      test_div_zero();
      test_flush();
      test_reset_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
